l1_dcache: RTL and testbench
============================

# l1_dcache

Direct-mapped, write-back, write-allocate L1 data cache with 1 KB capacity and 64 B lines. It sits between the CPU word-access port and the line-based L2 cache port, and is the direct upstream requester of the L2. CPU loads and stores are 32-bit words with byte strobes. All L2 traffic is whole-line: dirty-victim writeback and refill. A flush command writes back every dirty line.

## Interface
Parameters:
- NUM_SETS, 16, number of lines; index width 4
- LINE_SIZE, 64, bytes per line; offset width 6, word select is addr[5:2]
- TAG_WIDTH, 22, tag bits addr[31:10]

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_wstrb  in  4  byte enables for stores; bit n enables byte n
- cpu_rd / cpu_wr  in  1  level request; held with stable addr/data until the cpu_ready cycle, inclusive; never both high
- cpu_rdata  out  32  load data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- flush  in  1  one-cycle pulse: write back all dirty lines
- flush_done  out  1  one-cycle pulse when flush completes
- l2_addr  out  32  line address, bits [5:0]=0
- l2_wdata  out  512  writeback line
- l2_rd / l2_wr  out  1  one-cycle request strobe to L2
- l2_rdata  in  512  refill line, valid with l2_ready
- l2_ready  in  1  one-cycle L2 completion pulse

## Operation
- Arrays: valid, dirty, and tag per set, plus one 512-bit data line per set. Reset clears all valid and dirty bits. Data and tag contents are don't-care after reset.
- States: IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, FLUSH_SCAN, FLUSH_WB, FLUSH_WAIT.
- IDLE behaviour:
  - A flush pulse has priority: capture the flush and go to FLUSH_SCAN with set pointer 0.
  - Otherwise, if (cpu_rd|cpu_wr) and !cpu_ready, latch addr, wdata, wstrb, and op, then go to LOOKUP.
  - A request arriving in the same cycle as flush stays pending, because the CPU holds it.
- LOOKUP:
  - Hit (valid && tag match):
    - Read: cpu_rdata <= the selected word.
    - Write: merge wstrb bytes into the word and set dirty; cpu_rdata is unchanged.
    - cpu_ready <= 1, then go to IDLE.
  - Miss with valid && dirty victim: go to WB_REQ.
  - Miss otherwise: go to FILL_REQ.
- WB_REQ:
  - Drive l2_addr={victim tag, index, 6'b0}, l2_wdata=victim line, l2_wr=1 for exactly one cycle.
  - Then go to WB_WAIT.
- WB_WAIT: on l2_ready, clear the victim's dirty bit and go to FILL_REQ.
- FILL_REQ: drive l2_addr={req tag, index, 6'b0} and l2_rd=1 for one cycle, then go to FILL_WAIT.
- FILL_WAIT, on l2_ready:
  - Install l2_rdata, the tag, and valid=1.
  - Write: merge the strobed bytes into the installed line and set dirty=1.
  - Read: dirty=0 and cpu_rdata <= the selected word of l2_rdata.
  - cpu_ready <= 1, then go to IDLE.
- FLUSH_SCAN:
  - If set[ptr] is valid && dirty, go to FLUSH_WB.
  - Else if ptr==NUM_SETS-1, set flush_done <= 1 and go to IDLE.
  - Else ptr++.
- FLUSH_WB: one-cycle l2_wr of that line, then go to FLUSH_WAIT.
- FLUSH_WAIT, on l2_ready:
  - Clear dirty; valid is kept.
  - If ptr==last, set flush_done <= 1 and go to IDLE.
  - Else ptr++ and go to FLUSH_SCAN.
- l2_ready outside WB_WAIT, FILL_WAIT, or FLUSH_WAIT is ignored.
- Strobe rule: l2 requests are single-cycle pulses because L2 re-accepts any request level it sees while idle. l2_addr and l2_wdata are held until the matching l2_ready.

## Timing
- Reset values:
  - Outputs: cpu_ready=0, cpu_rdata=0, flush_done=0, l2_rd=0, l2_wr=0, l2_addr=0, l2_wdata=0.
  - Internal: state=IDLE, flush pointer=0.
- Reset asserted mid-transaction aborts immediately:
  - The strobes drop asynchronously.
  - Outstanding L2 work is abandoned; the system resets L2 together with this block.
- Hit latency:
  - Request sampled at edge E0, LOOKUP at E1.
  - cpu_ready is high in the cycle after E1, i.e. 2 cycles from request to ready.
  - The next request is accepted at the first edge after the ready cycle, giving 3 cycles per hit back-to-back.
- Clean miss:
  - l2_rd is high in the cycle after LOOKUP.
  - cpu_ready is high in the cycle after l2_ready is sampled.
- Dirty miss: the l2_wr pulse, then the wait for l2_ready, then the l2_rd pulse 1 cycle later.
- Flush:
  - Each clean set costs 1 cycle.
  - flush_done is high 1 cycle after the last set is handled.
  - An all-clean flush takes 16 cycles from the pulse to the flush_done cycle.
- cpu_ready, flush_done, l2_rd, and l2_wr are never high for 2 consecutive cycles.

## Test plan
- Cold read of 0x0000_1004 with L2 returning a line where word1=0xCAFEBABE:
  - One l2_rd with l2_addr=0x0000_1000.
  - cpu_rdata=0xCAFEBABE.
  - A repeat read hits: cpu_ready 2 cycles after the request, no L2 traffic.
- Write 0x11223344 with wstrb=4'b0101 to a cached word holding 0xAABBCCDD:
  - A following read returns 0xAA22CC44.
- Dirty eviction: write to 0x0000_0040, then read 0x0000_0440 (same set 1, different tag):
  - l2_wr with l2_addr=0x0000_0040 and the modified line.
  - Then l2_rd with l2_addr=0x0000_0440.
- Write miss to 0x0000_2008, data 0xDEADBEEF, wstrb=4'hF:
  - Refill l2_rd, then the line is dirty with word2=0xDEADBEEF.
  - A later flush writes exactly that line.
- Flush with sets 3 and 15 dirty:
  - Exactly two l2_wr pulses, in order set 3 then set 15.
  - Then one flush_done pulse.
  - A second flush produces zero writes and flush_done after 16 cycles.
- Assert rst during FILL_WAIT:
  - All outputs go to reset values immediately.
  - A read of the same address afterwards misses.

Source files
------------

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache.
//   NUM_SETS lines of LINE_SIZE bytes.
//   The CPU side is a 32-bit word port with byte strobes.
//   The L2 side moves whole lines only: victim writeback and refill.
//   flush writes every dirty line back to L2 and keeps it valid.
// Ports:
//   clk, rst                         clock, async active-high reset
//   cpu_addr/wdata/wstrb/rd/wr       CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready             load data and one-cycle completion pulse
//   flush, flush_done                flush command pulse and completion pulse
//   l2_addr/wdata/rd/wr              L2 line request; rd/wr are one-cycle strobes
//   l2_rdata, l2_ready               L2 refill data and completion pulse
module l1_dcache #(
    parameter int NUM_SETS  = 16,
    parameter int LINE_SIZE = 64,
    parameter int TAG_WIDTH = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    input  logic [3:0]             cpu_wstrb,
    input  logic                   cpu_rd,
    input  logic                   cpu_wr,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_ready,
    input  logic                   flush,
    output logic                   flush_done,
    output logic [31:0]            l2_addr,
    output logic [LINE_SIZE*8-1:0] l2_wdata,
    output logic                   l2_rd,
    output logic                   l2_wr,
    input  logic [LINE_SIZE*8-1:0] l2_rdata,
    input  logic                   l2_ready
);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int OFF_W  = $clog2(LINE_SIZE);
    localparam int WSEL_W = OFF_W - 2;
    localparam int LINE_W = LINE_SIZE * 8;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT,
        FLUSH_SCAN, FLUSH_WB, FLUSH_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                flush_pend_q, flush_pend_d;
    logic [31:2]         req_addr_q, req_addr_d;
    logic [31:0]         req_wdata_q, req_wdata_d;
    logic [3:0]          req_wstrb_q, req_wstrb_d;
    logic                req_wr_q, req_wr_d;
    logic [NUM_SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic                cpu_ready_q, cpu_ready_d, flush_done_q, flush_done_d;
    logic                l2_rd_q, l2_rd_d, l2_wr_q, l2_wr_d;
    logic [31:0]         cpu_rdata_q, cpu_rdata_d, l2_addr_q, l2_addr_d;
    logic [LINE_W-1:0]   l2_wdata_q, l2_wdata_d;

    // Tag and data arrays carry no reset; valid gates every use.
    logic [TAG_WIDTH-1:0] tag_q  [NUM_SETS];
    logic [LINE_W-1:0]    data_q [NUM_SETS];
    logic                 arr_we;
    logic [LINE_W-1:0]    arr_line;

    logic [IDX_W-1:0]     req_idx;
    logic [TAG_WIDTH-1:0] req_tag;
    logic [WSEL_W-1:0]    req_wsel;
    logic [LINE_W-1:0]    cur_line;
    logic                 hit;
    logic                 unused_addr_lsb;

    assign unused_addr_lsb = ^cpu_addr[1:0];
    assign req_idx  = req_addr_q[OFF_W +: IDX_W];
    assign req_tag  = req_addr_q[31 -: TAG_WIDTH];
    assign req_wsel = req_addr_q[2 +: WSEL_W];
    assign cur_line = data_q[req_idx];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Overlay the strobed bytes of wd onto word wsel of a line.
    function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] line,
                                                input logic [WSEL_W-1:0] wsel,
                                                input logic [31:0] wd,
                                                input logic [3:0] ws);
        merge = line;
        for (int b = 0; b < 4; b++)
            if (ws[b]) merge[int'(wsel)*32 + b*8 +: 8] = wd[b*8 +: 8];
    endfunction

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        flush_pend_d = flush_pend_q | flush;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_wstrb_d  = req_wstrb_q;
        req_wr_d     = req_wr_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        arr_we       = 1'b0;
        arr_line     = l2_rdata;
        cpu_ready_d  = 1'b0;
        flush_done_d = 1'b0;
        l2_rd_d      = 1'b0;
        l2_wr_d      = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        l2_addr_d    = l2_addr_q;
        l2_wdata_d   = l2_wdata_q;
        // L2 strobes are raised on the transition into the *_REQ/FLUSH_WB
        // state, so each one is high for exactly that state's single cycle.
        case (state_q)
            IDLE: begin
                if (flush || flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    ptr_d        = '0;
                    state_d      = FLUSH_SCAN;
                end else if ((cpu_rd || cpu_wr) && !cpu_ready_q) begin
                    // !cpu_ready_q keeps the still-held completed request out.
                    req_addr_d  = cpu_addr[31:2];
                    req_wdata_d = cpu_wdata;
                    req_wstrb_d = cpu_wstrb;
                    req_wr_d    = cpu_wr;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    if (req_wr_q) begin
                        arr_we           = 1'b1;
                        arr_line         = merge(cur_line, req_wsel, req_wdata_q, req_wstrb_q);
                        dirty_d[req_idx] = 1'b1;
                    end else begin
                        cpu_rdata_d = cur_line[{req_wsel, 5'b0} +: 32];
                    end
                    cpu_ready_d = 1'b1;
                    state_d     = IDLE;
                end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    l2_addr_d  = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
                    l2_wdata_d = cur_line;
                    l2_wr_d    = 1'b1;
                    state_d    = WB_REQ;
                end else begin
                    l2_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
                    l2_rd_d   = 1'b1;
                    state_d   = FILL_REQ;
                end
            end
            WB_REQ:   state_d = WB_WAIT;
            WB_WAIT: begin
                if (l2_ready) begin
                    dirty_d[req_idx] = 1'b0;
                    l2_addr_d        = {req_tag, req_idx, {OFF_W{1'b0}}};
                    l2_rd_d          = 1'b1;
                    state_d          = FILL_REQ;
                end
            end
            FILL_REQ: state_d = FILL_WAIT;
            FILL_WAIT: begin
                if (l2_ready) begin
                    arr_we           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = req_wr_q;
                    if (req_wr_q)
                        arr_line = merge(l2_rdata, req_wsel, req_wdata_q, req_wstrb_q);
                    else
                        cpu_rdata_d = l2_rdata[{req_wsel, 5'b0} +: 32];
                    cpu_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            FLUSH_SCAN: begin
                if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
                    l2_addr_d  = {tag_q[ptr_q], ptr_q, {OFF_W{1'b0}}};
                    l2_wdata_d = data_q[ptr_q];
                    l2_wr_d    = 1'b1;
                    state_d    = FLUSH_WB;
                end else if (ptr_q == IDX_W'(NUM_SETS - 1)) begin
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            FLUSH_WB: state_d = FLUSH_WAIT;
            FLUSH_WAIT: begin
                if (l2_ready) begin
                    dirty_d[ptr_q] = 1'b0;
                    if (ptr_q == IDX_W'(NUM_SETS - 1)) begin
                        flush_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        ptr_d   = ptr_q + IDX_W'(1);
                        state_d = FLUSH_SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            flush_pend_q <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
            req_wr_q     <= 1'b0;
            valid_q      <= '0;
            dirty_q      <= '0;
            cpu_ready_q  <= 1'b0;
            flush_done_q <= 1'b0;
            l2_rd_q      <= 1'b0;
            l2_wr_q      <= 1'b0;
            cpu_rdata_q  <= '0;
            l2_addr_q    <= '0;
            l2_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            flush_pend_q <= flush_pend_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_wstrb_q  <= req_wstrb_d;
            req_wr_q     <= req_wr_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            cpu_ready_q  <= cpu_ready_d;
            flush_done_q <= flush_done_d;
            l2_rd_q      <= l2_rd_d;
            l2_wr_q      <= l2_wr_d;
            cpu_rdata_q  <= cpu_rdata_d;
            l2_addr_q    <= l2_addr_d;
            l2_wdata_q   <= l2_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_q[req_idx] <= arr_line;
            tag_q[req_idx]  <= req_tag;
        end
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ready  = cpu_ready_q;
    assign flush_done = flush_done_q;
    assign l2_addr    = l2_addr_q;
    assign l2_wdata   = l2_wdata_q;
    assign l2_rd      = l2_rd_q;
    assign l2_wr      = l2_wr_q;
endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: directed scenarios plus a randomized run against a
// word-level memory model; L2 is a behavioural line store with variable latency.
module tb_l1_dcache;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]   cpu_wstrb = '0;
    logic         cpu_rd = 1'b0, cpu_wr = 1'b0, flush = 1'b0;
    logic [31:0]  cpu_rdata, l2_addr;
    logic         cpu_ready, flush_done, l2_rd, l2_wr;
    logic [511:0] l2_wdata, l2_rdata;
    logic         l2_ready;

    l1_dcache dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .flush(flush),
        .flush_done(flush_done), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rd(l2_rd), .l2_wr(l2_wr), .l2_rdata(l2_rdata), .l2_ready(l2_ready)
    );

    always #5 clk = ~clk;

    int ncmp = 0, nfail = 0;
    int l2_lat = 1;
    int pulse_viol = 0, done_cnt = 0;
    logic [3:0] prev_p = '0;

    logic [511:0] l2mem [logic [31:0]];
    logic [31:0]  ref_word [logic [31:0]];
    bit           ev_wr [$];
    logic [31:0]  ev_addr [$];
    logic [511:0] ev_data [$];

    function automatic logic [511:0] init_line(input logic [31:0] la);
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[w*32 +: 32] = {la[31:6], w[3:0], 2'b00} ^ 32'hA5A5_0000;
        return l;
    endfunction

    function automatic logic [511:0] get_line(input logic [31:0] la);
        if (l2mem.exists(la)) return l2mem[la];
        return init_line(la);
    endfunction

    function automatic logic [511:0] set_word(input logic [511:0] l, input int w, input logic [31:0] v);
        l[w*32 +: 32] = v;
        return l;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [511:0] ln;
        if (ref_word.exists({a[31:2], 2'b00})) return ref_word[{a[31:2], 2'b00}];
        ln = get_line({a[31:6], 6'b0});
        return ln[int'(a[5:2])*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // L2 model: logs every strobe, stores writebacks, answers after l2_lat cycles.
    initial begin
        bit pend = 0;
        bit pwr = 0;
        int cnt = 0;
        logic [31:0] paddr = '0;
        l2_ready = 1'b0;
        l2_rdata = '0;
        forever begin
            @(negedge clk);
            l2_ready = 1'b0;
            if (rst) pend = 0;
            else begin
                if (pend && cnt == 0) begin
                    l2_ready = 1'b1;
                    if (!pwr) l2_rdata = get_line(paddr);
                    pend = 0;
                end else if (pend) cnt--;
                if (l2_rd || l2_wr) begin
                    ev_wr.push_back(l2_wr); ev_addr.push_back(l2_addr); ev_data.push_back(l2_wdata);
                    if (l2_wr) l2mem[l2_addr] = l2_wdata;
                    pend = 1; pwr = l2_wr; paddr = l2_addr; cnt = l2_lat;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (({cpu_ready, flush_done, l2_rd, l2_wr} & prev_p) != 4'b0) pulse_viol++;
        prev_p = {cpu_ready, flush_done, l2_rd, l2_wr};
        if (flush_done) done_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr_ev();
        ev_wr.delete(); ev_addr.delete(); ev_data.delete();
    endtask

    task automatic cpu_op(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rd, output int lat);
        bit got = 0;
        @(negedge clk);
        cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws; cpu_rd = !wr; cpu_wr = wr;
        lat = 0; rd = 'x;
        while (!got && lat < 2000) begin
            @(posedge clk); #1; lat++;
            if (cpu_ready) begin got = 1; rd = cpu_rdata; end
        end
        chk("cpu_ready_seen", {511'b0, got}, 512'd1);
        if (got) begin @(posedge clk); #1; end
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic do_flush(output int edges);
        bit got = 0;
        int d0 = done_cnt;
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        edges = 0;
        while (!got && edges < 5000) begin
            @(posedge clk); #1; edges++;
            if (flush_done) got = 1;
        end
        chk("flush_done_seen", {511'b0, got}, 512'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("flush_done_count", done_cnt - d0, 1);
    endtask

    initial begin
        logic [31:0] rd, a, wd, old;
        logic [3:0]  ws;
        logic [511:0] ln;
        int lat, edges, k;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_l2_strobes", {l2_rd, l2_wr}, 0);
        chk("rst_l2_addr", l2_addr, 0);
        chk("rst_l2_wdata", l2_wdata, 0);
        @(negedge clk); rst = 1'b0;

        // Cold read then hit
        l2mem[32'h1000] = set_word(init_line(32'h1000), 1, 32'hCAFEBABE);
        l2mem[32'h3000] = set_word(init_line(32'h3000), 0, 32'hAABBCCDD);
        clr_ev();
        cpu_op(0, 32'h1004, 0, 0, rd, lat);
        chk("cold_rdata", rd, 32'hCAFEBABE);
        chk("cold_l2_count", ev_wr.size(), 1);
        chk("cold_l2_rd", {ev_wr[0], ev_addr[0]}, {1'b0, 32'h1000});
        clr_ev();
        cpu_op(0, 32'h1004, 0, 0, rd, lat);
        chk("hit_rdata", rd, 32'hCAFEBABE);
        chk("hit_latency", lat, 2);
        chk("hit_no_l2", ev_wr.size(), 0);

        // Strobed write merge
        cpu_op(0, 32'h3000, 0, 0, rd, lat);
        chk("merge_pre", rd, 32'hAABBCCDD);
        cpu_op(1, 32'h3000, 32'h11223344, 4'b0101, rd, lat);
        chk("write_hit_latency", lat, 2);
        cpu_op(0, 32'h3000, 0, 0, rd, lat);
        chk("merge_result", rd, 32'hAA22CC44);

        // Dirty eviction in set 1
        cpu_op(1, 32'h0040, 32'h12345678, 4'hF, rd, lat);
        clr_ev();
        cpu_op(0, 32'h0440, 0, 0, rd, lat);
        chk("evict_count", ev_wr.size(), 2);
        chk("evict_wb", {ev_wr[0], ev_addr[0]}, {1'b1, 32'h0040});
        chk("evict_wb_data", ev_data[0], set_word(init_line(32'h40), 0, 32'h12345678));
        chk("evict_fill", {ev_wr[1], ev_addr[1]}, {1'b0, 32'h0440});
        ln = init_line(32'h440);
        chk("evict_rdata", rd, ln[31:0]);

        // Write miss, then flush writes just that line
        clr_ev();
        cpu_op(1, 32'h2008, 32'hDEADBEEF, 4'hF, rd, lat);
        chk("wmiss_count", ev_wr.size(), 2);
        chk("wmiss_wb", {ev_wr[0], ev_addr[0]}, {1'b1, 32'h3000});
        chk("wmiss_wb_data", ev_data[0], set_word(init_line(32'h3000), 0, 32'hAA22CC44));
        chk("wmiss_fill", {ev_wr[1], ev_addr[1]}, {1'b0, 32'h2000});
        clr_ev();
        do_flush(edges);
        chk("wmiss_flush_count", ev_wr.size(), 1);
        chk("wmiss_flush_wr", {ev_wr[0], ev_addr[0]}, {1'b1, 32'h2000});
        chk("wmiss_flush_data", ev_data[0], set_word(init_line(32'h2000), 2, 32'hDEADBEEF));

        // Flush with sets 3 and 15 dirty, then an all-clean flush
        cpu_op(1, 32'h00C0, 32'h0BADF00D, 4'hF, rd, lat);
        cpu_op(1, 32'h03C4, 32'h600DCAFE, 4'hF, rd, lat);
        clr_ev();
        do_flush(edges);
        chk("flush2_count", ev_wr.size(), 2);
        chk("flush2_first", {ev_wr[0], ev_addr[0]}, {1'b1, 32'h00C0});
        chk("flush2_first_data", ev_data[0], set_word(init_line(32'hC0), 0, 32'h0BADF00D));
        chk("flush2_second", {ev_wr[1], ev_addr[1]}, {1'b1, 32'h03C0});
        chk("flush2_second_data", ev_data[1], set_word(init_line(32'h3C0), 1, 32'h600DCAFE));
        clr_ev();
        do_flush(edges);
        chk("clean_flush_writes", ev_wr.size(), 0);
        chk("clean_flush_cycles", edges, 16);

        // Randomized traffic against the word-level model (cache is clean here)
        for (int i = 0; i < 250; i++) begin
            l2_lat = $urandom_range(0, 3);
            a = 32'h8000 + ($urandom_range(0, 3) << 10) + ($urandom_range(0, 15) << 6)
                + ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 29) == 0) do_flush(edges);
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom; ws = 4'($urandom_range(0, 15));
                old = ref_read(a);
                for (int b = 0; b < 4; b++) if (ws[b]) old[b*8 +: 8] = wd[b*8 +: 8];
                ref_word[a] = old;
                cpu_op(1, a, wd, ws, rd, lat);
            end else begin
                cpu_op(0, a, 0, 0, rd, lat);
                chk("rand_read", rd, ref_read(a));
            end
        end
        do_flush(edges);
        foreach (ref_word[w]) begin
            ln = get_line({w[31:6], 6'b0});
            chk("l2_after_flush", ln[int'(w[5:2])*32 +: 32], ref_word[w]);
        end

        // Reset during FILL_WAIT
        l2_lat = 30;
        clr_ev();
        @(negedge clk); cpu_addr = 32'h5000; cpu_rd = 1'b1;
        for (k = 0; k < 100 && ev_wr.size() == 0; k++) @(negedge clk);
        chk("rstfill_l2_rd", ev_wr.size(), 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstfill_strobes", {cpu_ready, flush_done, l2_rd, l2_wr}, 0);
        chk("rstfill_cpu_rdata", cpu_rdata, 0);
        chk("rstfill_l2_addr", l2_addr, 0);
        chk("rstfill_l2_wdata", l2_wdata, 0);
        cpu_rd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; l2_lat = 1;
        clr_ev();
        cpu_op(0, 32'h5000, 0, 0, rd, lat);
        chk("post_rst_miss", ev_wr.size(), 1);
        chk("post_rst_fill", {ev_wr[0], ev_addr[0]}, {1'b0, 32'h5000});
        ln = get_line(32'h5000);
        chk("post_rst_rdata", rd, ln[31:0]);

        chk("single_cycle_pulses", pulse_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
